uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial receive front end for the single-cycle CPU's UART peripheral.
- Sits directly upstream of the CPU's UART read register; consumes the raw rx pin.
- Recovers 8N1 frames with 16x oversampling and buffers received bytes in a small first-word-fall-through FIFO.
- The CPU reads bytes from the FIFO and pops them with a one-cycle read strobe; framing-error and overrun status are sticky flags for the CPU to read.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz
BAUD, 9600, serial bit rate
OVERSAMPLE, 16, baud ticks per bit; fixed at 16, other values unsupported
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
rx  input  1  raw serial line, idle high, asynchronous to clk
rd_en  input  1  pop strobe from the CPU; one pop per cycle high
clr_err  input  1  clears frame_err and overrun
rx_data  output  8  FIFO head byte; valid only while rx_valid=1
rx_valid  output  1  FIFO not empty
rx_full  output  1  FIFO holds FIFO_DEPTH bytes
frame_err  output  1  sticky: stop bit sampled as 0
overrun  output  1  sticky: byte arrived while FIFO full and not popped

Behaviour:
- Reset: async on rst=1.
  - Outputs: rx_data=0x00, rx_valid=0, rx_full=0, frame_err=0, overrun=0.
  - Internals: FIFO empty, FSM=IDLE, synchronizer flops=1, tick divider=0.
  - Reset mid-frame discards the partial byte. Reception restarts only on the next falling edge after rst deasserts.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s, so there is 2 cycles of input latency.
- Tick generator: DIV = CLK_FREQ/(BAUD*16), integer truncation (175 at defaults). tick pulses one cycle every DIV clocks.
  - The divider free-runs, but is cleared when IDLE detects a start edge, so that start-bit phase is aligned.
- FSM states and transitions:
  - IDLE: wait for rx_s 1->0. On the edge, clear the divider and tick counter, then go to START.
  - START: on the 8th tick (bit middle), sample rx_s.
    - If rx_s=1, it is a glitch: go to IDLE with no flag.
    - If rx_s=0, go to DATA with bit index 0.
  - DATA: every 16 ticks, sample rx_s into shift[idx], LSB first. After idx 7 is sampled, go to STOP.
  - STOP: 16 ticks later (stop-bit middle), sample rx_s.
    - If rx_s=1, push the byte.
    - If rx_s=0, set frame_err and discard the byte.
    - Either way, go to IDLE in the same cycle. This allows a new start edge half a bit later, so back-to-back frames are supported.
- FIFO:
  - Push happens on the clk edge of the stop sample. rx_valid rises the following cycle.
  - rx_data always shows the head entry (first-word fall-through).
  - rd_en with rx_valid=1 pops at the edge; the next byte, or rx_valid=0, is visible the next cycle.
  - rd_en with rx_valid=0 is ignored; no pointer change.
  - Push while full and no pop in the same cycle: drop the new byte, set overrun. Contents stay unchanged.
  - Push and pop in the same cycle while full: both occur, no overrun, count unchanged.
  - Push and pop in the same cycle while count=1: the new byte becomes head, rx_valid stays 1.
  - Pointers wrap modulo FIFO_DEPTH. The count is a separate log2(DEPTH)+1-bit counter. rx_full = (count==FIFO_DEPTH).
- Sticky flags:
  - frame_err and overrun set on their events and clear only on clr_err=1 or reset.
  - clr_err and a set event in the same cycle: the set wins.
- Break condition (rx held low): produces a frame_err once, then FSM waits in IDLE for rx_s to return high before arming a new edge.

Test Plan:
- Reset, then serial 8N1 at 104166 ns/bit, data bits 0,1,0,1,0,0,0,0 (LSB first), stop 1 -> rx_valid=1, rx_data=0x0A about 9.5 bit times after the start edge; frame_err=0.
- 0x0A immediately followed by a frame with bits 1,0,1,0,0,0,0,0 and no pop -> FIFO holds 0x0A then 0x05. rd_en pulse -> rx_data=0x05. Second pulse -> rx_valid=0.
- 5 bytes 0x11..0x15 with no reads, depth 4 -> rx_full=1, overrun=1. Popping returns 0x11,0x12,0x13,0x14; 0x15 is lost. clr_err clears overrun.
- Frame 0x3C with stop bit driven 0 -> frame_err=1, rx_valid stays 0. A next valid frame 0x7E is received correctly.
- rx low pulse of 3 µs (shorter than half a bit) -> no byte, no flag, FSM back in IDLE.
- rst asserted during bit 4 of a frame -> all outputs 0 immediately. The following full frame 0xA5 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with 16x oversampling and a FWFT byte FIFO.
// Sticky framing/overrun flags are held until clr_err or reset.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]  LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [PW:0] FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic            rx_prev;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      tick_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            tick;
  logic            fall;
  logic            stop_sample;
  logic            push;
  logic            ferr_set;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            do_pop;
  logic            do_push;
  logic            ovr_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // A falling edge only counts when the line was seen high first, so a held
  // break cannot re-arm the receiver until the line returns to idle.
  assign fall = (state == IDLE) && rx_prev && !rx_s;
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (fall || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign stop_sample = (state == STOP) && tick && (tick_cnt == LAST_TICK);
  assign push        = stop_sample && rx_s;
  assign ferr_set    = stop_sample && !rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            tick_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt       <= '0;
              shift[bit_idx] <= rx_s;
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_valid = (count != '0);
  assign rx_full  = (count == FULL_CNT);
  assign do_pop   = rd_en && rx_valid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push  = push && (!rx_full || do_pop);
  assign ovr_set  = push && rx_full && !do_pop;
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo.
module tb_uart_rx_fifo;
  localparam int BIT   = 64;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full;
  logic       frame_err;
  logic       overrun;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_ferr = 1'b0;
  logic       exp_ovr = 1'b0;

  uart_rx_fifo #(
    .CLK_FREQ(614400),
    .BAUD(9600),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rd_en(rd_en),
    .clr_err(clr_err),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_full(rx_full),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic model_frame(input logic [7:0] data, input logic stop);
    if (!stop) exp_ferr = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(data);
    else exp_ovr = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop);
    model_frame(data, stop);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
    check({tag, ".full"}, 32'(rx_full), 32'(exp_q.size() == DEPTH));
    check({tag, ".ferr"}, 32'(frame_err), 32'(exp_ferr));
    check({tag, ".ovr"}, 32'(overrun), 32'(exp_ovr));
    if (exp_q.size() != 0) check({tag, ".data"}, 32'(rx_data), 32'(exp_q[0]));
  endtask

  task automatic pop(input string tag);
    check({tag, ".valid"}, 32'(rx_valid), 32'd1);
    if (exp_q.size() != 0) check({tag, ".data"}, 32'(rx_data), 32'(exp_q.pop_front()));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] first;

    repeat (3) @(negedge clk);
    check_state("reset");
    check("reset.data", 32'(rx_data), 32'h00);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);

    // First byte: the stop-bit sample should land about half a bit into the stop bit.
    first = 8'h0A;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(first[i]);
    rx = 1'b1;
    n = 0;
    while (!rx_valid && n < 2 * BIT) begin
      @(negedge clk);
      n++;
    end
    check("lat.valid", 32'(rx_valid), 32'd1);
    check("lat.window", 32'(n >= BIT / 2 - 4 && n <= BIT / 2 + 12), 32'd1);
    if (n < BIT) repeat (BIT - n) @(negedge clk);
    model_frame(first, 1'b1);
    send_frame(8'h05, 1'b1);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    check_state("b2b");
    pop("b2b.pop0");
    pop("b2b.pop1");
    check_state("b2b.empty");

    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_state("empty_pop");

    for (int i = 0; i < 5; i++) send_frame(8'h11 + 8'(i), 1'b1);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    check_state("ovr");
    for (int i = 0; i < DEPTH; i++) pop("ovr.pop");
    check_state("ovr.drained");
    pulse_clr();
    check_state("ovr.clr");

    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check_state("ferr");
    send_frame(8'h7E, 1'b1);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    check_state("ferr.next");

    // 150 ns low pulse is well under half a 640 ns bit.
    rx = 1'b0;
    repeat (15) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check_state("glitch");
    send_frame(8'h5A, 1'b1);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    check_state("glitch.next");

    first = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(first[i]);
    rx = first[4];
    repeat (BIT / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
    check_state("midrst");
    check("midrst.data", 32'(rx_data), 32'h00);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'hA5, 1'b1);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    check_state("midrst.next");

    // Break: one framing error, then no re-trigger while the line stays low.
    rx = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    exp_ferr = 1'b1;
    check_state("break");
    pulse_clr();
    repeat (5 * BIT) @(negedge clk);
    check_state("break.held");
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    check_state("break.next");
    pop("final.pop0");
    pop("final.pop1");
    check_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
